ffra_dot_seq: RTL

Operand sequencer that sits directly upstream of the `ffra` datapath and closes its accumulate loop. A Wishbone-loaded buffer holds up to DEPTH (a, b) byte pairs. On start, the block drives them one pair at a time onto `ffra`'s a/b inputs, with ci fed from the running 16-bit result. It captures `ffra`'s o after a fixed number of cycles and exposes the final value, a busy flag and a done interrupt to the management SoC.

---
 rtl/ffra_dot_seq.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/ffra_dot_seq.sv
// Operand sequencer for the ffra datapath: a Wishbone-loaded buffer of (a, b) pairs is
// streamed onto ffra one pair at a time while ci is fed back from the running result.
module ffra_dot_seq #(
    parameter int DEPTH = 8,
    parameter int LAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [7:0]  op_a,
    output logic [7:0]  op_b,
    output logic [15:0] op_ci,
    input  logic [15:0] res_i,
    output logic        busy,
    output logic        done_irq
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(LAT - 1);
    localparam logic [4:0]    DEPTH_W   = 5'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          next_s;
    logic            ack_r;
    logic [31:0]     dat_r;
    logic [7:0]      op_a_r;
    logic [7:0]      op_b_r;
    logic [15:0]     op_ci_r;
    logic            busy_r;
    logic            done_r;
    logic [4:0]      count_r;
    logic [15:0]     init_r;
    logic [15:0]     acc_r;
    logic [4:0]      idx_r;
    logic [HW-1:0]   hold_r;
    logic [15:0]     opnd_r [DEPTH];

    logic            req_s;
    logic            wr_s;
    logic [5:0]      word_s;
    logic            cfg_wr_s;
    logic            start_s;
    logic            clr_s;
    logic            cap_s;
    logic            last_s;
    logic            opnd_hit_s;
    logic [AW-1:0]   slot_s;
    logic [4:0]      count_wr_s;
    logic [4:0]      idx_nxt_s;
    logic [15:0]     acc_nxt_s;
    logic [HW-1:0]   hold_nxt_s;
    logic [31:0]     rd_data_s;
    logic            unused_s;

    assign unused_s = ^{wbs_sel_i, wbs_adr_i[31:8], wbs_adr_i[1:0], wbs_dat_i[31:16]};

    assign req_s      = wbs_stb_i & wbs_cyc_i & ~ack_r;
    assign wr_s       = req_s & wbs_we_i;
    assign word_s     = wbs_adr_i[7:2];
    // Configuration is frozen while a sequence is running; CTRL bits are gated the same way.
    assign cfg_wr_s   = wr_s & (state_r != ST_RUN);
    assign start_s    = cfg_wr_s & (word_s == 6'd0) & wbs_dat_i[0];
    assign clr_s      = cfg_wr_s & (word_s == 6'd0) & wbs_dat_i[1];
    assign cap_s      = (state_r == ST_RUN) & (hold_r == HOLD_LAST);
    assign last_s     = cap_s & (idx_r == (count_r - 5'd1));
    assign opnd_hit_s = (word_s[5:4] == 2'b01) & ({1'b0, word_s[3:0]} < DEPTH_W);
    assign slot_s     = word_s[AW-1:0];
    assign count_wr_s = (wbs_dat_i[4:0] > DEPTH_W) ? DEPTH_W : wbs_dat_i[4:0];

    assign wbs_ack_o = ack_r;
    assign wbs_dat_o = dat_r;
    assign op_a      = op_a_r;
    assign op_b      = op_b_r;
    assign op_ci     = op_ci_r;
    assign busy      = busy_r;
    assign done_irq  = done_r;

    // Next-state decode for the IDLE/RUN/DONE sequencer.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    next_s = (count_r == 5'd0) ? ST_DONE : ST_RUN;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    next_s = ST_DONE;
                end else begin
                    next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start_s) begin
                    next_s = (count_r == 5'd0) ? ST_DONE : ST_RUN;
                end else if (clr_s) begin
                    next_s = ST_IDLE;
                end else begin
                    next_s = ST_DONE;
                end
            end
            default: next_s = ST_IDLE;
        endcase
    end

    // Next values of pair index, accumulator and per-pair hold counter.
    always_comb begin
        idx_nxt_s  = idx_r;
        acc_nxt_s  = acc_r;
        hold_nxt_s = hold_r;
        if (start_s) begin
            idx_nxt_s  = 5'd0;
            acc_nxt_s  = init_r;
            hold_nxt_s = '0;
        end else if (state_r == ST_RUN) begin
            if (cap_s) begin
                idx_nxt_s  = idx_r + 5'd1;
                acc_nxt_s  = res_i;
                hold_nxt_s = '0;
            end else begin
                hold_nxt_s = hold_r + HW'(1);
            end
        end else begin
            idx_nxt_s  = idx_r;
            acc_nxt_s  = acc_r;
            hold_nxt_s = hold_r;
        end
    end

    // Register read mux; sees already-updated acc so a read in the done cycle is final.
    always_comb begin
        rd_data_s = 32'd0;
        case (word_s)
            6'd0: rd_data_s = {27'd0, done_r, busy_r, idx_r[2:0]};
            6'd1: rd_data_s = {27'd0, count_r};
            6'd2: rd_data_s = {16'd0, init_r};
            6'd3: rd_data_s = {16'd0, acc_r};
            default: begin
                if (opnd_hit_s) begin
                    rd_data_s = {16'd0, opnd_r[slot_s]};
                end else begin
                    rd_data_s = 32'd0;
                end
            end
        endcase
    end

    // Wishbone acknowledge and registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_r <= 1'b0;
            dat_r <= 32'd0;
        end else begin
            ack_r <= req_s;
            if (req_s & ~wbs_we_i) begin
                dat_r <= rd_data_s;
            end
        end
    end

    // FSM state and sequencing registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= 5'd0;
            acc_r   <= 16'd0;
            hold_r  <= '0;
        end else begin
            state_r <= next_s;
            idx_r   <= idx_nxt_s;
            acc_r   <= acc_nxt_s;
            hold_r  <= hold_nxt_s;
        end
    end

    // Configuration registers and operand buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 5'd0;
            init_r  <= 16'd0;
            for (int i = 0; i < DEPTH; i++) begin
                opnd_r[i] <= 16'd0;
            end
        end else if (cfg_wr_s) begin
            case (word_s)
                6'd1: count_r <= count_wr_s;
                6'd2: init_r  <= wbs_dat_i[15:0];
                default: begin
                    if (opnd_hit_s) begin
                        opnd_r[slot_s] <= wbs_dat_i[15:0];
                    end
                end
            endcase
        end
    end

    // Registered outputs toward ffra and the SoC, driven from next-cycle values.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_r  <= 8'd0;
            op_b_r  <= 8'd0;
            op_ci_r <= 16'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            busy_r <= (next_s == ST_RUN);
            done_r <= (next_s == ST_DONE);
            if (next_s == ST_RUN) begin
                op_a_r  <= opnd_r[idx_nxt_s[AW-1:0]][7:0];
                op_b_r  <= opnd_r[idx_nxt_s[AW-1:0]][15:8];
                op_ci_r <= acc_nxt_s;
            end else begin
                op_a_r  <= 8'd0;
                op_b_r  <= 8'd0;
                op_ci_r <= 16'd0;
            end
        end
    end

endmodule
